// File: rtl/lfsr_pkg.sv
// ----------------------------------------------------------------------------
// lfsr_pkg
// Shared constants and the LFSR stepping function for the channel scheduler.
//   LFSR_W        : LFSR state width (16).
//   DEFAULT_SEED  : state used at reset, on reseed and instead of a zero seed.
//   DEFAULT_POLY  : feedback tap mask.
//   lfsr_advance  : runs nbits steps, returning the final state and the
//                   keystream (bit i = output bit of step i).
// ----------------------------------------------------------------------------
package lfsr_pkg;

    localparam int unsigned LFSR_W = 16;

    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hFFFF;
    localparam logic [LFSR_W-1:0] DEFAULT_POLY = 16'h801C;

    typedef struct packed {
        logic [LFSR_W-1:0] state;
        logic [LFSR_W-1:0] keystream;
    } lfsr_step_t;

    // One step: out = s[15], fb = ^(s & poly), s' = {s[14:0], fb}.
    // Only the low nbits keystream bits are meaningful; the rest stay zero.
    function automatic lfsr_step_t lfsr_advance(
        input logic [LFSR_W-1:0] state,
        input logic [LFSR_W-1:0] poly,
        input int unsigned       nbits
    );
        lfsr_step_t        r;
        logic [LFSR_W-1:0] s;
        logic              fb;
        s           = state;
        fb          = 1'b0;
        r.keystream = '0;
        for (int unsigned i = 0; i < LFSR_W; i++) begin
            if (i < nbits) begin
                r.keystream[i] = s[LFSR_W-1];
                fb             = ^(s & poly);
                s              = {s[LFSR_W-2:0], fb};
            end
        end
        r.state = s;
        return r;
    endfunction

endpackage

// File: rtl/lfsr_channel_scheduler_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter. Searches the request vector starting at
// the pointer position and wrapping at p_N-1 -> 0; the first requester found
// wins.
//   i_req   : request vector (p_N bits).
//   i_ptr   : index where the search starts (highest priority this cycle).
//   o_grant : one-hot grant, or zero when no request.
//   o_idx   : index of the granted requester (zero when none).
//   o_any   : at least one request was granted.
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int p_N = 4
) (
    input  logic [p_N-1:0]         i_req,
    input  logic [$clog2(p_N)-1:0] i_ptr,
    output logic [p_N-1:0]         o_grant,
    output logic [$clog2(p_N)-1:0] o_idx,
    output logic                   o_any
);

    localparam int IW = $clog2(p_N);

    int unsigned cand;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        cand    = 0;
        for (int unsigned k = 0; k < p_N; k++) begin
            // Pointer is always < p_N, so a single subtraction wraps.
            cand = 32'(i_ptr) + k;
            if (cand >= p_N) begin
                cand = cand - p_N;
            end
            if (!o_any && i_req[cand[IW-1:0]]) begin
                o_any                  = 1'b1;
                o_grant[cand[IW-1:0]] = 1'b1;
                o_idx                  = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/lfsr_channel_scheduler.sv
// ----------------------------------------------------------------------------
// lfsr_channel_scheduler
// Time-shares one parallel LFSR scrambler between p_CHANNELS requesters. Each
// channel owns a 16-bit LFSR state; one request per cycle is granted by
// round-robin, XORed with that channel's keystream and presented through a
// single registered valid/ready output stage.
//   i_CLK, i_RESET_N          : clock, synchronous active-low reset.
//   i_REQ_VALID/o_REQ_READY   : per-channel request handshake (ready one-hot).
//   i_REQ_DATA                : channel c word at [c*B +: B].
//   i_REQ_RESEED              : scramble this word from p_RESET_SEED.
//   o_OUT_VALID/i_OUT_READY   : output handshake.
//   o_OUT_DATA, o_OUT_CHAN    : scrambled word and its channel tag.
//   i_CFG_WE/CHAN/SEED        : direct write of a channel's LFSR state.
// ----------------------------------------------------------------------------
module lfsr_channel_scheduler
    import lfsr_pkg::*;
#(
    parameter int                p_CHANNELS       = 4,
    parameter int                p_BITS_PER_CLOCK = 8,
    parameter logic [LFSR_W-1:0] p_RESET_SEED     = DEFAULT_SEED,
    parameter logic [LFSR_W-1:0] p_POLYNOMIAL     = DEFAULT_POLY
) (
    input  logic                                     i_CLK,
    input  logic                                     i_RESET_N,
    input  logic [p_CHANNELS-1:0]                    i_REQ_VALID,
    output logic [p_CHANNELS-1:0]                    o_REQ_READY,
    input  logic [p_CHANNELS*p_BITS_PER_CLOCK-1:0]   i_REQ_DATA,
    input  logic [p_CHANNELS-1:0]                    i_REQ_RESEED,
    output logic                                     o_OUT_VALID,
    input  logic                                     i_OUT_READY,
    output logic [p_BITS_PER_CLOCK-1:0]              o_OUT_DATA,
    output logic [$clog2(p_CHANNELS)-1:0]            o_OUT_CHAN,
    input  logic                                     i_CFG_WE,
    input  logic [$clog2(p_CHANNELS)-1:0]            i_CFG_CHAN,
    input  logic [LFSR_W-1:0]                        i_CFG_SEED
);

    localparam int CW = $clog2(p_CHANNELS);
    localparam int B  = p_BITS_PER_CLOCK;

    logic [LFSR_W-1:0] state_q [p_CHANNELS];
    logic [LFSR_W-1:0] state_d [p_CHANNELS];
    logic [CW-1:0]     ptr_q, ptr_d;
    logic              out_valid_q, out_valid_d;
    logic [B-1:0]      out_data_q, out_data_d;
    logic [CW-1:0]     out_chan_q, out_chan_d;

    logic                  slot_free;
    logic [p_CHANNELS-1:0] arb_req;
    logic [p_CHANNELS-1:0] grant;
    logic [CW-1:0]         grant_idx;
    logic                  grant_any;
    logic [LFSR_W-1:0]     seed_sel;
    lfsr_step_t            adv;
    logic [B-1:0]          req_word;
    logic [B-1:0]          scrambled;
    logic [LFSR_W-1:0]     cfg_value;
    logic                  cfg_hit;

    // Requests are masked while the output stage is full or reset is held,
    // so the arbiter's grant is directly the ready strobe.
    assign slot_free = !out_valid_q || i_OUT_READY;
    assign arb_req   = (slot_free && i_RESET_N) ? i_REQ_VALID : '0;

    rr_arbiter #(
        .p_N (p_CHANNELS)
    ) u_arb (
        .i_req   (arb_req),
        .i_ptr   (ptr_q),
        .o_grant (grant),
        .o_idx   (grant_idx),
        .o_any   (grant_any)
    );

    assign o_REQ_READY = grant;

    // Scrambler datapath for the granted channel.
    always_comb begin
        seed_sel  = i_REQ_RESEED[grant_idx] ? p_RESET_SEED : state_q[grant_idx];
        adv       = lfsr_advance(seed_sel, p_POLYNOMIAL, 32'(B));
        req_word  = i_REQ_DATA[32'(grant_idx)*B +: B];
        scrambled = req_word ^ adv.keystream[B-1:0];
    end

    // A zero seed would lock the LFSR, so it is replaced by the reset seed.
    assign cfg_value = (i_CFG_SEED == '0) ? p_RESET_SEED : i_CFG_SEED;
    assign cfg_hit   = i_CFG_WE && (32'(i_CFG_CHAN) < 32'(p_CHANNELS));

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;

        if (grant_any) begin
            state_d[grant_idx] = adv.state;
            ptr_d              = (grant_idx == CW'(p_CHANNELS - 1)) ? '0
                                                                     : grant_idx + 1'b1;
            out_valid_d        = 1'b1;
            out_data_d         = scrambled;
            out_chan_d         = grant_idx;
        end else if (i_OUT_READY) begin
            out_valid_d = 1'b0;
        end

        // Applied after the accept so a same-cycle config write owns the
        // stored state, while the accepted word already used the old one.
        if (cfg_hit) begin
            state_d[i_CFG_CHAN] = cfg_value;
        end
    end

    always_ff @(posedge i_CLK) begin
        if (!i_RESET_N) begin
            for (int unsigned i = 0; i < p_CHANNELS; i++) begin
                state_q[i] <= p_RESET_SEED;
            end
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
        end
    end

    assign o_OUT_VALID = out_valid_q;
    assign o_OUT_DATA  = out_data_q;
    assign o_OUT_CHAN  = out_chan_q;

endmodule

// File: tb/tb_lfsr_channel_scheduler.sv
// ----------------------------------------------------------------------------
// tb_lfsr_channel_scheduler
// Self-checking bench for lfsr_channel_scheduler with default parameters
// (4 channels, 8-bit words). A reference model predicts grants and pushes
// expected output words into a queue; words are popped and compared when the
// output handshake completes.
// ----------------------------------------------------------------------------
module tb_lfsr_channel_scheduler;

    logic        i_CLK;
    logic        i_RESET_N;
    logic [3:0]  i_REQ_VALID;
    logic [3:0]  o_REQ_READY;
    logic [31:0] i_REQ_DATA;
    logic [3:0]  i_REQ_RESEED;
    logic        o_OUT_VALID;
    logic        i_OUT_READY;
    logic [7:0]  o_OUT_DATA;
    logic [1:0]  o_OUT_CHAN;
    logic        i_CFG_WE;
    logic [1:0]  i_CFG_CHAN;
    logic [15:0] i_CFG_SEED;

    lfsr_channel_scheduler #(
        .p_CHANNELS       (4),
        .p_BITS_PER_CLOCK (8),
        .p_RESET_SEED     (16'hFFFF),
        .p_POLYNOMIAL     (16'h801C)
    ) dut (
        .i_CLK        (i_CLK),
        .i_RESET_N    (i_RESET_N),
        .i_REQ_VALID  (i_REQ_VALID),
        .o_REQ_READY  (o_REQ_READY),
        .i_REQ_DATA   (i_REQ_DATA),
        .i_REQ_RESEED (i_REQ_RESEED),
        .o_OUT_VALID  (o_OUT_VALID),
        .i_OUT_READY  (i_OUT_READY),
        .o_OUT_DATA   (o_OUT_DATA),
        .o_OUT_CHAN   (o_OUT_CHAN),
        .i_CFG_WE     (i_CFG_WE),
        .i_CFG_CHAN   (i_CFG_CHAN),
        .i_CFG_SEED   (i_CFG_SEED)
    );

    initial i_CLK = 1'b0;
    always #5 i_CLK = ~i_CLK;

    typedef struct {
        logic [7:0] data;
        logic [1:0] chan;
    } exp_t;

    exp_t        sb [$];
    logic [15:0] m_state [4];
    int          m_ptr;
    bit          m_ov;
    int          n_checks;
    int          n_fail;

    // Reference scrambler: taps 15,4,3,2 written out explicitly.
    function automatic logic [7:0] model_word(input logic [15:0] seed,
                                              input logic [7:0]  din,
                                              output logic [15:0] nxt);
        logic [15:0] s;
        logic [7:0]  ks;
        s  = seed;
        ks = '0;
        for (int i = 0; i < 8; i++) begin
            ks[i] = s[15];
            s     = {s[14:0], s[15] ^ s[4] ^ s[3] ^ s[2]};
        end
        nxt = s;
        return din ^ ks;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_state[i] = 16'hFFFF;
        m_ptr = 0;
        m_ov  = 1'b0;
        sb.delete();
    endtask

    // One clock cycle: drive at the negedge, check combinational ready and
    // the current output, update the model, then advance to the next negedge.
    task automatic step(input logic [3:0]  v,
                        input logic [31:0] d,
                        input logic [3:0]  rs,
                        input logic        ordy,
                        input logic        we,
                        input logic [1:0]  cch,
                        input logic [15:0] cseed);
        bit          slot_free;
        int          g;
        int          c;
        logic [3:0]  exp_ready;
        logic [15:0] nxt;
        logic [15:0] seed;
        exp_t        e;
        i_REQ_VALID  = v;
        i_REQ_DATA   = d;
        i_REQ_RESEED = rs;
        i_OUT_READY  = ordy;
        i_CFG_WE     = we;
        i_CFG_CHAN   = cch;
        i_CFG_SEED   = cseed;
        #1;
        slot_free = !m_ov || ordy;
        g = -1;
        if (slot_free) begin
            for (int k = 0; k < 4; k++) begin
                c = (m_ptr + k) % 4;
                if (g < 0 && v[c]) g = c;
            end
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;

        n_checks++;
        if (o_REQ_READY !== exp_ready) begin
            n_fail++;
            $display("FAIL req_ready: got %b expected %b (t=%0t)", o_REQ_READY, exp_ready, $time);
        end
        n_checks++;
        if (o_OUT_VALID !== m_ov) begin
            n_fail++;
            $display("FAIL out_valid: got %b expected %b (t=%0t)", o_OUT_VALID, m_ov, $time);
        end

        if (m_ov && ordy && sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            if (o_OUT_DATA !== e.data) begin
                n_fail++;
                $display("FAIL out_data: got %h expected %h (t=%0t)", o_OUT_DATA, e.data, $time);
            end
            n_checks++;
            if (o_OUT_CHAN !== e.chan) begin
                n_fail++;
                $display("FAIL out_chan: got %0d expected %0d (t=%0t)", o_OUT_CHAN, e.chan, $time);
            end
        end

        if (g >= 0) begin
            seed   = rs[g] ? 16'hFFFF : m_state[g];
            e.data = model_word(seed, d[g*8 +: 8], nxt);
            e.chan = 2'(g);
            sb.push_back(e);
            m_state[g] = nxt;
            m_ptr      = (g + 1) % 4;
        end
        if (we) m_state[cch] = (cseed == 16'h0) ? 16'hFFFF : cseed;
        if (g >= 0)    m_ov = 1'b1;
        else if (ordy) m_ov = 1'b0;

        @(posedge i_CLK);
        @(negedge i_CLK);
    endtask

    task automatic idle(input logic ordy);
        step(4'b0000, 32'h0, 4'b0000, ordy, 1'b0, 2'd0, 16'h0);
    endtask

    task automatic do_reset();
        i_RESET_N   = 1'b0;
        i_REQ_VALID = 4'b1111;
        i_OUT_READY = 1'b1;
        i_CFG_WE    = 1'b0;
        #1;
        n_checks++;
        if (o_REQ_READY !== 4'b0000) begin
            n_fail++;
            $display("FAIL ready_in_reset: got %b expected 0000", o_REQ_READY);
        end
        @(posedge i_CLK); @(negedge i_CLK);
        @(posedge i_CLK); @(negedge i_CLK);
        i_RESET_N   = 1'b1;
        i_REQ_VALID = 4'b0000;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({o_OUT_VALID, o_OUT_DATA, o_OUT_CHAN} !== 11'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b d=%h c=%0d expected all zero",
                     o_OUT_VALID, o_OUT_DATA, o_OUT_CHAN);
        end
        n_checks++;
        if (dut.ptr_q !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_ptr: got %0d expected 0", dut.ptr_q);
        end
    endtask

    task automatic test_single_channel();
        step(4'b0001, 32'h0, 4'b0000, 1'b1, 1'b0, 2'd0, 16'h0);
        n_checks++;
        if (dut.state_q[0] !== 16'hFF14) begin
            n_fail++;
            $display("FAIL state_after_word1: got %h expected ff14", dut.state_q[0]);
        end
        step(4'b0001, 32'h0, 4'b0000, 1'b1, 1'b0, 2'd0, 16'h0);
        step(4'b0001, 32'h0, 4'b0000, 1'b1, 1'b0, 2'd0, 16'h0);
        idle(1'b1);
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 4; i++)
            step(4'b1111, 32'h0, 4'b0000, 1'b1, 1'b0, 2'd0, 16'h0);
        for (int i = 0; i < 8; i++)
            step(4'b1111, $urandom, 4'b0000, 1'b1, 1'b0, 2'd0, 16'h0);
        step(4'b1010, $urandom, 4'b0000, 1'b1, 1'b0, 2'd0, 16'h0);
        step(4'b1010, $urandom, 4'b0000, 1'b1, 1'b0, 2'd0, 16'h0);
        idle(1'b1);
    endtask

    task automatic test_stall();
        logic [7:0] cap_d;
        logic [1:0] cap_c;
        step(4'b1111, $urandom, 4'b0000, 1'b1, 1'b0, 2'd0, 16'h0);
        cap_d = o_OUT_DATA;
        cap_c = o_OUT_CHAN;
        for (int i = 0; i < 5; i++) begin
            step(4'b1111, $urandom, 4'b1111, 1'b0, 1'b0, 2'd0, 16'h0);
            n_checks++;
            if (o_OUT_DATA !== cap_d || o_OUT_CHAN !== cap_c) begin
                n_fail++;
                $display("FAIL stall_hold: got %h/%0d expected %h/%0d",
                         o_OUT_DATA, o_OUT_CHAN, cap_d, cap_c);
            end
        end
        step(4'b1111, $urandom, 4'b0000, 1'b1, 1'b0, 2'd0, 16'h0);
        idle(1'b1);
    endtask

    task automatic test_config();
        step(4'b0000, 32'h0, 4'b0000, 1'b1, 1'b1, 2'd2, 16'h0000);
        step(4'b0100, 32'h0, 4'b0000, 1'b1, 1'b0, 2'd0, 16'h0);
        step(4'b0000, 32'h0, 4'b0000, 1'b1, 1'b1, 2'd2, 16'h1400);
        step(4'b0100, 32'h0, 4'b0000, 1'b1, 1'b0, 2'd0, 16'h0);
        // Accept and config write on the same channel in one cycle.
        step(4'b0100, 32'h00A50000, 4'b0000, 1'b1, 1'b1, 2'd2, 16'hBEEF);
        step(4'b0100, 32'h0, 4'b0000, 1'b1, 1'b0, 2'd0, 16'h0);
        idle(1'b1);
    endtask

    task automatic test_reseed();
        step(4'b0010, 32'h00003C00, 4'b0000, 1'b1, 1'b0, 2'd0, 16'h0);
        step(4'b0010, 32'h00001200, 4'b0000, 1'b1, 1'b0, 2'd0, 16'h0);
        // Reseed on a channel that is not granted must be ignored.
        step(4'b0000, 32'h0, 4'b0010, 1'b1, 1'b0, 2'd0, 16'h0);
        step(4'b0010, 32'h0, 4'b0010, 1'b1, 1'b0, 2'd0, 16'h0);
        n_checks++;
        if (dut.state_q[1] !== 16'hFF14) begin
            n_fail++;
            $display("FAIL reseed_state: got %h expected ff14", dut.state_q[1]);
        end
        idle(1'b1);
    endtask

    task automatic test_mid_reset();
        step(4'b1111, $urandom, 4'b0000, 1'b1, 1'b0, 2'd0, 16'h0);
        step(4'b1111, $urandom, 4'b0000, 1'b1, 1'b0, 2'd0, 16'h0);
        step(4'b1111, $urandom, 4'b0000, 1'b0, 1'b0, 2'd0, 16'h0);
        do_reset();
        n_checks++;
        if (o_OUT_VALID !== 1'b0 || dut.ptr_q !== 2'd0) begin
            n_fail++;
            $display("FAIL mid_reset: got valid=%b ptr=%0d expected 0/0", o_OUT_VALID, dut.ptr_q);
        end
        step(4'b0001, 32'h0, 4'b0000, 1'b1, 1'b0, 2'd0, 16'h0);
        idle(1'b1);
    endtask

    task automatic test_back_to_back();
        logic       we;
        logic [3:0] rs;
        for (int i = 0; i < 300; i++) begin
            we = ($urandom_range(0, 9) == 0);
            rs = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
            step(4'($urandom), $urandom, rs, ($urandom_range(0, 3) != 0), we,
                 2'($urandom), ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom));
        end
        idle(1'b1);
        idle(1'b1);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        i_RESET_N    = 1'b0;
        i_REQ_VALID  = '0;
        i_REQ_DATA   = '0;
        i_REQ_RESEED = '0;
        i_OUT_READY  = 1'b0;
        i_CFG_WE     = 1'b0;
        i_CFG_CHAN   = '0;
        i_CFG_SEED   = '0;
        model_reset();
        @(negedge i_CLK);
        test_reset();
        test_single_channel();
        test_round_robin();
        test_stall();
        test_config();
        test_reseed();
        test_mid_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
